// File: rtl/fpu_pkg.sv
// Shared FPU definitions: special-result codes, binary32 constants and the
// divider FSM state encoding.
package fpu_pkg;

    localparam logic [1:0] FP_NORMAL = 2'b00;
    localparam logic [1:0] FP_ZERO   = 2'b01;
    localparam logic [1:0] FP_INF    = 2'b10;
    localparam logic [1:0] FP_NAN    = 2'b11;

    localparam int          FP_BIAS  = 127;
    localparam int unsigned FP_SIG_W = 24;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StDiv,
        StDone
    } fdiv_state_e;

endpackage

// File: rtl/flzc24.sv
// Combinational leading-zero counter for a 24-bit significand; all-zero
// input reports 24.
module flzc24
    import fpu_pkg::*;
(
    input  logic [FP_SIG_W-1:0] val,
    output logic [4:0]          cnt
);

    // Ascending scan: the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (val[i]) begin
                cnt = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative radix-2 restoring binary32 divider producing an unrounded
// sign/significand/exponent triple plus special codes for the rounder.
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int unsigned ITER = 26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        sign_o,
    output logic [31:0] sig_o,
    output logic [7:0]  exp_o,
    output logic [1:0]  special_o,
    output logic        nv_o,
    output logic        dz_o,
    output logic        ovf_o,
    output logic        unf_o
);

    localparam logic signed [9:0] Bias = 10'(FP_BIAS);

    fdiv_state_e state_q, state_d;
    logic        load_ops, prep_en, div_en;

    logic [31:0]       a_q, b_q;
    logic [24:0]       r_q;
    logic [23:0]       mb_q;
    logic [24:0]       q_q;
    logic [4:0]        cnt_q;
    logic signed [9:0] e_q;

    logic        sign_q, nv_q, dz_q, ovf_q, unf_q;
    logic [31:0] sig_q;
    logic [7:0]  exp_q;
    logic [1:0]  special_q;

    // Operand classification
    logic [7:0]  ea, eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [1:0]  spec_code;
    logic        spec_nv, spec_dz, is_special;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign a_nan  = (ea == 8'hff) && (a_q[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hff) && (b_q[22:0] != 23'd0);
    assign a_inf  = (ea == 8'hff) && (a_q[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hff) && (b_q[22:0] == 23'd0);
    assign a_zero = (ea == 8'h00) && (a_q[22:0] == 23'd0);
    assign b_zero = (eb == 8'h00) && (b_q[22:0] == 23'd0);

    always_comb begin
        spec_code = FP_NORMAL;
        spec_nv   = 1'b0;
        spec_dz   = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_code = FP_NAN;
            spec_nv   = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_code = FP_INF;
            spec_dz   = 1'b1;
        end else if (a_inf) begin
            spec_code = FP_INF;
        end else if (a_zero || b_inf) begin
            spec_code = FP_ZERO;
        end
    end

    assign is_special = (spec_code != FP_NORMAL);

    // Subnormal normalization
    logic [23:0]       ma_raw, mb_raw, ma_norm, mb_norm;
    logic [4:0]        lz_a, lz_b;
    logic signed [9:0] ea_eff, eb_eff, e_prep;

    assign ma_raw = {ea != 8'h00, a_q[22:0]};
    assign mb_raw = {eb != 8'h00, b_q[22:0]};

    flzc24 u_lzc_a (
        .val (ma_raw),
        .cnt (lz_a)
    );

    flzc24 u_lzc_b (
        .val (mb_raw),
        .cnt (lz_b)
    );

    assign ma_norm = ma_raw << lz_a;
    assign mb_norm = mb_raw << lz_b;
    assign ea_eff  = (ea == 8'h00) ? (10'sd1 - $signed({5'd0, lz_a})) : $signed({2'd0, ea});
    assign eb_eff  = (eb == 8'h00) ? (10'sd1 - $signed({5'd0, lz_b})) : $signed({2'd0, eb});
    assign e_prep  = ea_eff - eb_eff + Bias;

    // One restoring step; r < 2*mb always holds, so 24 bits of the difference suffice.
    logic              r_ge, last;
    logic [23:0]       r_sub;
    logic [24:0]       r_nx;
    logic [25:0]       q_nx;
    logic signed [9:0] exp_fin;
    logic [31:0]       sig_fin;

    assign r_ge    = (r_q >= {1'b0, mb_q});
    assign r_sub   = r_q[23:0] - mb_q;
    assign r_nx    = r_ge ? {r_sub, 1'b0} : {r_q[23:0], 1'b0};
    assign q_nx    = {q_q, r_ge};
    assign last    = (cnt_q == 5'(ITER - 1));
    assign exp_fin = q_nx[25] ? e_q : (e_q - 10'sd1);
    assign sig_fin = q_nx[25] ? {q_nx[25:1], 6'd0, q_nx[0] | (r_nx != 25'd0)}
                              : {q_nx[24:0], 6'd0, r_nx != 25'd0};

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid_i) state_d = StPrep;
            StPrep: state_d = is_special ? StDone : StDiv;
            StDiv:  if (last) state_d = StDone;
            StDone: if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and datapath enables
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        load_ops    = (state_q == StIdle) && in_valid_i;
        prep_en     = (state_q == StPrep);
        div_en      = (state_q == StDiv);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            mb_q      <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            e_q       <= '0;
            sign_q    <= 1'b0;
            sig_q     <= '0;
            exp_q     <= '0;
            special_q <= FP_NORMAL;
            nv_q      <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (load_ops) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (prep_en) begin
                r_q   <= {1'b0, ma_norm};
                mb_q  <= mb_norm;
                q_q   <= '0;
                cnt_q <= '0;
                e_q   <= e_prep;
                if (is_special) begin
                    sign_q    <= a_q[31] ^ b_q[31];
                    sig_q     <= '0;
                    exp_q     <= '0;
                    special_q <= spec_code;
                    nv_q      <= spec_nv;
                    dz_q      <= spec_dz;
                    ovf_q     <= 1'b0;
                    unf_q     <= 1'b0;
                end
            end
            if (div_en) begin
                r_q   <= r_nx;
                q_q   <= q_nx[24:0];
                cnt_q <= cnt_q + 5'd1;
                if (last) begin
                    sign_q    <= a_q[31] ^ b_q[31];
                    sig_q     <= sig_fin;
                    exp_q     <= exp_fin[7:0];
                    special_q <= FP_NORMAL;
                    nv_q      <= 1'b0;
                    dz_q      <= 1'b0;
                    ovf_q     <= (exp_fin >= 10'sd255);
                    unf_q     <= (exp_fin <= 10'sd0);
                end
            end
        end
    end

    assign sign_o    = sign_q;
    assign sig_o     = sig_q;
    assign exp_o     = exp_q;
    assign special_o = special_q;
    assign nv_o      = nv_q;
    assign dz_o      = dz_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;

endmodule
